id_stage_pipe: RTL and testbench

ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

---
 rtl/id_stage_pipe_if.sv | 41 ++++
 rtl/id_stage_pipe.sv | 130 +++++++++++++
 tb/tb_id_stage_pipe.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_pipe_if.sv
// IF/ID -> ID/EX boundary signals for the decode stage: upstream instruction slot,
// writeback port, hazard/stall feedback and the registered ID/EX payload.
interface id_stage_pipe_if #(
    parameter int DATA_W = 32
);
    logic              if_valid;
    logic [31:0]       if_pc;
    logic [31:0]       if_instr;
    logic              flush;
    logic              out_ready;
    logic              reg_write;
    logic [4:0]        write_reg;
    logic [DATA_W-1:0] write_data;

    logic              stall_out;
    logic              ex_valid;
    logic [31:0]       pc_out;
    logic [DATA_W-1:0] rd1_out;
    logic [DATA_W-1:0] rd2_out;
    logic [DATA_W-1:0] imm_out;
    logic [4:0]        rs_out;
    logic [4:0]        rt_out;
    logic [4:0]        rd_out;
    logic [1:0]        wb_out;
    logic [2:0]        mem_out;
    logic [3:0]        ex_out;

    modport master (
        output if_valid, if_pc, if_instr, flush, out_ready,
               reg_write, write_reg, write_data,
        input  stall_out, ex_valid, pc_out, rd1_out, rd2_out, imm_out,
               rs_out, rt_out, rd_out, wb_out, mem_out, ex_out
    );

    modport slave (
        input  if_valid, if_pc, if_instr, flush, out_ready,
               reg_write, write_reg, write_data,
        output stall_out, ex_valid, pc_out, rd1_out, rd2_out, imm_out,
               rs_out, rt_out, rd_out, wb_out, mem_out, ex_out
    );
endinterface

// File: rtl/id_stage_pipe.sv
// MIPS-style instruction decode stage: register file with write-through bypass,
// control decode, load-use hazard detection and the ID/EX pipeline register.
module id_stage_pipe #(
    parameter int DATA_W  = 32,
    parameter int REG_CNT = 32
) (
    input  logic         clk,
    input  logic         rst,
    id_stage_pipe_if.slave bus
);
    localparam int REG_AW = $clog2(REG_CNT);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    typedef struct packed {
        logic [1:0] wb;   // {RegWrite, MemtoReg}
        logic [2:0] mem;  // {Branch, MemRead, MemWrite}
        logic [3:0] ex;   // {RegDst, ALUOp[1:0], ALUSrc}
    } ctrl_t;

    typedef struct packed {
        logic              valid;
        ctrl_t             ctrl;
        logic [31:0]       pc;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
    } idex_t;

    logic [5:0]        opcode;
    logic [4:0]        rs, rt, rd;
    logic [REG_AW-1:0] rs_a, rt_a, wr_a, ex_rt_a;
    logic              wr_en;
    logic [DATA_W-1:0] rd1, rd2, imm;
    logic [DATA_W-1:0] regs [REG_CNT];
    ctrl_t             dec_ctrl;
    idex_t             idex_q, idex_d, load_val;
    logic              hazard;

    assign opcode = bus.if_instr[31:26];
    assign rs     = bus.if_instr[25:21];
    assign rt     = bus.if_instr[20:16];
    assign rd     = bus.if_instr[15:11];
    assign imm    = {{(DATA_W-16){bus.if_instr[15]}}, bus.if_instr[15:0]};

    // Register indices drop the upper field bits when REG_CNT < 32, so aliases
    // (e.g. 9 -> 1 with eight registers) resolve to the same storage.
    assign rs_a    = rs[REG_AW-1:0];
    assign rt_a    = rt[REG_AW-1:0];
    assign wr_a    = bus.write_reg[REG_AW-1:0];
    assign ex_rt_a = idex_q.rt[REG_AW-1:0];
    assign wr_en   = bus.reg_write && (wr_a != '0);

    always_ff @(posedge clk) begin
        // NOTE: the register file is cleared on reset, so it is built from flops rather than
        // a RAM macro, which cannot be reset in a single cycle.
        // NOTE: non-blocking assignments make every flop sample pre-edge values,
        // independent of statement order.
        if (rst) begin
            for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[wr_a] <= bus.write_data;
        end
    end

    // Same-cycle writeback bypasses the array so ID sees the value being written.
    assign rd1 = (rs_a == '0)                 ? '0             :
                 (wr_en && (wr_a == rs_a))    ? bus.write_data : regs[rs_a];
    assign rd2 = (rt_a == '0)                 ? '0             :
                 (wr_en && (wr_a == rt_a))    ? bus.write_data : regs[rt_a];

    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven; without it
        // an unlisted opcode would hold the old value and infer a latch.
        dec_ctrl = '0;
        case (opcode)
            OP_RTYPE: dec_ctrl = '{wb: 2'b10, mem: 3'b000, ex: 4'b1100};
            OP_LW:    dec_ctrl = '{wb: 2'b11, mem: 3'b010, ex: 4'b0001};
            OP_SW:    dec_ctrl = '{wb: 2'b00, mem: 3'b001, ex: 4'b0001};
            OP_BEQ:   dec_ctrl = '{wb: 2'b00, mem: 3'b100, ex: 4'b0010};
            default:  dec_ctrl = '0;
        endcase
    end

    // A load in ID/EX whose destination feeds the instruction in IF/ID.
    assign hazard = bus.if_valid && idex_q.valid && idex_q.ctrl.mem[1] &&
                    (ex_rt_a != '0) && ((ex_rt_a == rs_a) || (ex_rt_a == rt_a));

    assign load_val = '{valid: 1'b1, ctrl: dec_ctrl, pc: bus.if_pc,
                        rd1: rd1, rd2: rd2, imm: imm, rs: rs, rt: rt, rd: rd};

    // Flush and bubble both capture the data fields but zero valid and controls.
    always_comb begin
        idex_d = load_val;
        if (bus.flush) begin
            idex_d.valid = 1'b0;
            idex_d.ctrl  = '0;
        end else if (!bus.out_ready) begin
            idex_d = idex_q;
        end else if (hazard || !bus.if_valid) begin
            idex_d.valid = 1'b0;
            idex_d.ctrl  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) idex_q <= '0;
        else     idex_q <= idex_d;
    end

    assign bus.stall_out = (!bus.out_ready || hazard) && !bus.flush && !rst;

    assign bus.ex_valid = idex_q.valid;
    assign bus.wb_out   = idex_q.ctrl.wb;
    assign bus.mem_out  = idex_q.ctrl.mem;
    assign bus.ex_out   = idex_q.ctrl.ex;
    assign bus.pc_out   = idex_q.pc;
    assign bus.rd1_out  = idex_q.rd1;
    assign bus.rd2_out  = idex_q.rd2;
    assign bus.imm_out  = idex_q.imm;
    assign bus.rs_out   = idex_q.rs;
    assign bus.rt_out   = idex_q.rt;
    assign bus.rd_out   = idex_q.rd;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Table-driven scoreboard bench for id_stage_pipe (32-bit instance) plus a
// hand-written sequence for the 64-bit / 8-register configuration.
module tb_id_stage_pipe;
    typedef struct {
        logic        valid;
        logic [1:0]  wb;
        logic [2:0]  mem;
        logic [3:0]  ex;
        logic [31:0] pc, rd1, rd2, imm;
        logic [4:0]  rs, rt, rd;
    } idex_t;

    typedef struct {
        logic [4:0]  f;      // {rst, if_valid, flush, out_ready, reg_write}
        logic [4:0]  wreg;
        logic [31:0] wdata, pc, instr;
        logic        stall;
        idex_t       exp;
    } vec_t;

    localparam logic [31:0] I_ADD  = 32'h0022_1820;  // add $3,$1,$2
    localparam logic [31:0] I_ADD0 = 32'h0000_1820;  // add $3,$0,$0
    localparam logic [31:0] I_ADD2 = 32'h0044_1820;  // add $3,$2,$4
    localparam logic [31:0] I_LW   = 32'h8C22_0000;  // lw  $2,0($1)
    localparam logic [31:0] I_SW   = 32'hAC22_0004;  // sw  $2,4($1)
    localparam logic [31:0] I_BEQ  = 32'h1022_FFFF;  // beq $1,$2,-1
    localparam logic [31:0] I_ADDI = 32'h2022_8000;  // addi $2,$1,0x8000

    localparam logic [8:0] C_R    = 9'b10_000_1100;
    localparam logic [8:0] C_LW   = 9'b11_010_0001;
    localparam logic [8:0] C_SW   = 9'b00_001_0001;
    localparam logic [8:0] C_BEQ  = 9'b00_100_0010;
    localparam logic [8:0] C_NONE = 9'b00_000_0000;

    logic clk = 1'b0;
    logic rst, rst64;
    int   n_checks = 0;
    int   n_errors = 0;
    vec_t  vecs[$];
    idex_t sb_q[$];
    idex_t e_zero;

    always #5 clk = ~clk;

    id_stage_pipe_if #(.DATA_W(32)) bus ();
    id_stage_pipe_if #(.DATA_W(64)) bus64 ();

    id_stage_pipe #(.DATA_W(32), .REG_CNT(32)) dut (.clk(clk), .rst(rst), .bus(bus));
    id_stage_pipe #(.DATA_W(64), .REG_CNT(8))  dut64 (.clk(clk), .rst(rst64), .bus(bus64));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic idex_t mk_exp(input logic v, input logic [8:0] ctl, input logic [31:0] pc,
                                     input logic [31:0] rd1, input logic [31:0] rd2,
                                     input logic [31:0] imm, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [4:0] rd);
        idex_t e;
        e.valid = v;
        e.wb = ctl[8:7]; e.mem = ctl[6:4]; e.ex = ctl[3:0];
        e.pc = pc; e.rd1 = rd1; e.rd2 = rd2; e.imm = imm;
        e.rs = rs; e.rt = rt; e.rd = rd;
        return e;
    endfunction

    function automatic vec_t mk_vec(input logic [4:0] f, input logic [4:0] wreg,
                                    input logic [31:0] wdata, input logic [31:0] pc,
                                    input logic [31:0] instr, input logic stall, input idex_t e);
        vec_t v;
        v.f = f; v.wreg = wreg; v.wdata = wdata; v.pc = pc; v.instr = instr;
        v.stall = stall; v.exp = e;
        return v;
    endfunction

    task automatic compare_idex(input string tag, input idex_t e);
        check({tag, " ex_valid"}, {63'd0, bus.ex_valid}, {63'd0, e.valid});
        check({tag, " wb_out"},   {62'd0, bus.wb_out},   {62'd0, e.wb});
        check({tag, " mem_out"},  {61'd0, bus.mem_out},  {61'd0, e.mem});
        check({tag, " ex_out"},   {60'd0, bus.ex_out},   {60'd0, e.ex});
        check({tag, " pc_out"},   {32'd0, bus.pc_out},   {32'd0, e.pc});
        check({tag, " rd1_out"},  {32'd0, bus.rd1_out},  {32'd0, e.rd1});
        check({tag, " rd2_out"},  {32'd0, bus.rd2_out},  {32'd0, e.rd2});
        check({tag, " imm_out"},  {32'd0, bus.imm_out},  {32'd0, e.imm});
        check({tag, " rs_out"},   {59'd0, bus.rs_out},   {59'd0, e.rs});
        check({tag, " rt_out"},   {59'd0, bus.rt_out},   {59'd0, e.rt});
        check({tag, " rd_out"},   {59'd0, bus.rd_out},   {59'd0, e.rd});
    endtask

    // Drive one cycle of stimulus, check the combinational stall, then compare
    // the ID/EX register after the edge against the scoreboard entry.
    task automatic apply_vec(input int idx, input vec_t v);
        idex_t e;
        rst            = v.f[4];
        bus.if_valid   = v.f[3];
        bus.flush      = v.f[2];
        bus.out_ready  = v.f[1];
        bus.reg_write  = v.f[0];
        bus.write_reg  = v.wreg;
        bus.write_data = v.wdata;
        bus.if_pc      = v.pc;
        bus.if_instr   = v.instr;
        sb_q.push_back(v.exp);
        #2;
        check($sformatf("v%0d stall_out", idx), {63'd0, bus.stall_out}, {63'd0, v.stall});
        @(posedge clk); #1;
        e = sb_q.pop_front();
        compare_idex($sformatf("v%0d", idx), e);
    endtask

    task automatic step64(input logic we, input logic [4:0] wreg, input logic [63:0] wdata,
                          input logic [31:0] instr);
        bus64.reg_write  = we;
        bus64.write_reg  = wreg;
        bus64.write_data = wdata;
        bus64.if_instr   = instr;
        @(posedge clk); #1;
    endtask

    initial begin
        e_zero = mk_exp(1'b0, C_NONE, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);

        vecs.push_back(mk_vec(5'b01010, 5'd0, 32'h0,    32'h04, I_ADD,  1'b0, mk_exp(1'b1, C_R,    32'h04, 32'h0,    32'h0,    32'h1820,     5'd1, 5'd2, 5'd3)));
        vecs.push_back(mk_vec(5'b01011, 5'd1, 32'h1234, 32'h08, I_ADD,  1'b0, mk_exp(1'b1, C_R,    32'h08, 32'h1234, 32'h0,    32'h1820,     5'd1, 5'd2, 5'd3)));
        vecs.push_back(mk_vec(5'b01011, 5'd2, 32'h5678, 32'h0C, I_ADD,  1'b0, mk_exp(1'b1, C_R,    32'h0C, 32'h1234, 32'h5678, 32'h1820,     5'd1, 5'd2, 5'd3)));
        vecs.push_back(mk_vec(5'b01011, 5'd0, 32'hDEAD, 32'h10, I_ADD0, 1'b0, mk_exp(1'b1, C_R,    32'h10, 32'h0,    32'h0,    32'h1820,     5'd0, 5'd0, 5'd3)));
        vecs.push_back(mk_vec(5'b01010, 5'd0, 32'h0,    32'h14, I_ADD0, 1'b0, mk_exp(1'b1, C_R,    32'h14, 32'h0,    32'h0,    32'h1820,     5'd0, 5'd0, 5'd3)));
        vecs.push_back(mk_vec(5'b01010, 5'd0, 32'h0,    32'h18, I_SW,   1'b0, mk_exp(1'b1, C_SW,   32'h18, 32'h1234, 32'h5678, 32'h4,        5'd1, 5'd2, 5'd0)));
        vecs.push_back(mk_vec(5'b01010, 5'd0, 32'h0,    32'h1C, I_BEQ,  1'b0, mk_exp(1'b1, C_BEQ,  32'h1C, 32'h1234, 32'h5678, 32'hFFFFFFFF, 5'd1, 5'd2, 5'd31)));
        vecs.push_back(mk_vec(5'b01010, 5'd0, 32'h0,    32'h20, I_ADDI, 1'b0, mk_exp(1'b1, C_NONE, 32'h20, 32'h1234, 32'h5678, 32'hFFFF8000, 5'd1, 5'd2, 5'd16)));
        vecs.push_back(mk_vec(5'b00010, 5'd0, 32'h0,    32'h24, I_ADD,  1'b0, mk_exp(1'b0, C_NONE, 32'h24, 32'h1234, 32'h5678, 32'h1820,     5'd1, 5'd2, 5'd3)));
        // load-use through rs: one bubble, then the consumer loads
        vecs.push_back(mk_vec(5'b01010, 5'd0, 32'h0,    32'h28, I_LW,   1'b0, mk_exp(1'b1, C_LW,   32'h28, 32'h1234, 32'h5678, 32'h0,        5'd1, 5'd2, 5'd0)));
        vecs.push_back(mk_vec(5'b01010, 5'd0, 32'h0,    32'h2C, I_ADD2, 1'b1, mk_exp(1'b0, C_NONE, 32'h2C, 32'h5678, 32'h0,    32'h1820,     5'd2, 5'd4, 5'd3)));
        vecs.push_back(mk_vec(5'b01010, 5'd0, 32'h0,    32'h2C, I_ADD2, 1'b0, mk_exp(1'b1, C_R,    32'h2C, 32'h5678, 32'h0,    32'h1820,     5'd2, 5'd4, 5'd3)));
        // load-use through rt
        vecs.push_back(mk_vec(5'b01010, 5'd0, 32'h0,    32'h30, I_LW,   1'b0, mk_exp(1'b1, C_LW,   32'h30, 32'h1234, 32'h5678, 32'h0,        5'd1, 5'd2, 5'd0)));
        vecs.push_back(mk_vec(5'b01010, 5'd0, 32'h0,    32'h34, I_SW,   1'b1, mk_exp(1'b0, C_NONE, 32'h34, 32'h1234, 32'h5678, 32'h4,        5'd1, 5'd2, 5'd0)));
        vecs.push_back(mk_vec(5'b01010, 5'd0, 32'h0,    32'h34, I_SW,   1'b0, mk_exp(1'b1, C_SW,   32'h34, 32'h1234, 32'h5678, 32'h4,        5'd1, 5'd2, 5'd0)));
        // load followed by an independent instruction: no stall
        vecs.push_back(mk_vec(5'b01010, 5'd0, 32'h0,    32'h38, I_LW,   1'b0, mk_exp(1'b1, C_LW,   32'h38, 32'h1234, 32'h5678, 32'h0,        5'd1, 5'd2, 5'd0)));
        vecs.push_back(mk_vec(5'b01010, 5'd0, 32'h0,    32'h3C, I_ADD0, 1'b0, mk_exp(1'b1, C_R,    32'h3C, 32'h0,    32'h0,    32'h1820,     5'd0, 5'd0, 5'd3)));
        // EX back-pressure for three cycles, then resume
        repeat (3)
            vecs.push_back(mk_vec(5'b01000, 5'd0, 32'h0, 32'h40, I_SW,  1'b1, mk_exp(1'b1, C_R,    32'h3C, 32'h0,    32'h0,    32'h1820,     5'd0, 5'd0, 5'd3)));
        vecs.push_back(mk_vec(5'b01010, 5'd0, 32'h0,    32'h40, I_SW,   1'b0, mk_exp(1'b1, C_SW,   32'h40, 32'h1234, 32'h5678, 32'h4,        5'd1, 5'd2, 5'd0)));
        // flush during a hazard, then flush during a hold
        vecs.push_back(mk_vec(5'b01010, 5'd0, 32'h0,    32'h44, I_LW,   1'b0, mk_exp(1'b1, C_LW,   32'h44, 32'h1234, 32'h5678, 32'h0,        5'd1, 5'd2, 5'd0)));
        vecs.push_back(mk_vec(5'b01110, 5'd0, 32'h0,    32'h48, I_ADD2, 1'b0, mk_exp(1'b0, C_NONE, 32'h48, 32'h5678, 32'h0,    32'h1820,     5'd2, 5'd4, 5'd3)));
        vecs.push_back(mk_vec(5'b01010, 5'd0, 32'h0,    32'h4C, I_ADD,  1'b0, mk_exp(1'b1, C_R,    32'h4C, 32'h1234, 32'h5678, 32'h1820,     5'd1, 5'd2, 5'd3)));
        vecs.push_back(mk_vec(5'b01100, 5'd0, 32'h0,    32'h50, I_SW,   1'b0, mk_exp(1'b0, C_NONE, 32'h50, 32'h1234, 32'h5678, 32'h4,        5'd1, 5'd2, 5'd0)));
        // reset mid-hazard clears ID/EX and the register file
        vecs.push_back(mk_vec(5'b01010, 5'd0, 32'h0,    32'h54, I_LW,   1'b0, mk_exp(1'b1, C_LW,   32'h54, 32'h1234, 32'h5678, 32'h0,        5'd1, 5'd2, 5'd0)));
        vecs.push_back(mk_vec(5'b11010, 5'd0, 32'h0,    32'h58, I_ADD2, 1'b0, e_zero));
        vecs.push_back(mk_vec(5'b01010, 5'd0, 32'h0,    32'h5C, I_ADD2, 1'b0, mk_exp(1'b1, C_R,    32'h5C, 32'h0,    32'h0,    32'h1820,     5'd2, 5'd4, 5'd3)));
        // reset mid-hold, then hold, bubble, load
        vecs.push_back(mk_vec(5'b11000, 5'd0, 32'h0,    32'h60, I_SW,   1'b0, e_zero));
        vecs.push_back(mk_vec(5'b01000, 5'd0, 32'h0,    32'h64, I_SW,   1'b1, e_zero));
        vecs.push_back(mk_vec(5'b00010, 5'd0, 32'h0,    32'h68, I_SW,   1'b0, mk_exp(1'b0, C_NONE, 32'h68, 32'h0,    32'h0,    32'h4,        5'd1, 5'd2, 5'd0)));
        vecs.push_back(mk_vec(5'b01010, 5'd0, 32'h0,    32'h6C, I_SW,   1'b0, mk_exp(1'b1, C_SW,   32'h6C, 32'h0,    32'h0,    32'h4,        5'd1, 5'd2, 5'd0)));

        // Reset phase: stall suppressed even with EX not ready
        rst = 1'b1; rst64 = 1'b1;
        bus.if_valid = 1'b1; bus.if_instr = I_ADD; bus.if_pc = 32'h0;
        bus.flush = 1'b0; bus.out_ready = 1'b0;
        bus.reg_write = 1'b0; bus.write_reg = 5'd0; bus.write_data = 32'h0;
        bus64.if_valid = 1'b1; bus64.if_instr = 32'h0; bus64.if_pc = 32'h0;
        bus64.flush = 1'b0; bus64.out_ready = 1'b1;
        bus64.reg_write = 1'b0; bus64.write_reg = 5'd0; bus64.write_data = 64'h0;
        #2;
        check("reset stall_out", {63'd0, bus.stall_out}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        compare_idex("reset", e_zero);

        for (int i = 0; i < vecs.size(); i++) apply_vec(i, vecs[i]);
        check("scoreboard drained", 64'(sb_q.size()), 64'd0);

        // 64-bit, eight registers: sign extension and 5-bit field aliasing
        rst64 = 1'b0;
        step64(1'b1, 5'd1, 64'h1111_2222_3333_4444, 32'h2120_8000);  // rs=9 -> reg 1
        check("w64 bypass rd1", bus64.rd1_out, 64'h1111_2222_3333_4444);
        check("w64 imm",        bus64.imm_out, 64'hFFFF_FFFF_FFFF_8000);
        check("w64 rs_out",     {59'd0, bus64.rs_out}, 64'd9);
        check("w64 ex_valid",   {63'd0, bus64.ex_valid}, 64'd1);
        check("w64 wb_out",     {62'd0, bus64.wb_out}, 64'd0);
        step64(1'b0, 5'd0, 64'h0, 32'h2120_8000);
        check("w64 alias rd1",  bus64.rd1_out, 64'h1111_2222_3333_4444);
        step64(1'b1, 5'd9, 64'hABCD, 32'h2020_8000);                 // write 9 -> reg 1
        check("w64 alias wr bypass", bus64.rd1_out, 64'hABCD);
        step64(1'b0, 5'd0, 64'h0, 32'h2020_8000);
        check("w64 alias wr rd1", bus64.rd1_out, 64'hABCD);
        step64(1'b1, 5'd8, 64'hFFFF, 32'h2028_8000);                 // write 8 -> reg 0
        check("w64 reg8 bypass rd2", bus64.rd2_out, 64'h0);
        check("w64 reg8 rd1",        bus64.rd1_out, 64'hABCD);
        step64(1'b0, 5'd0, 64'h0, 32'h2028_8000);
        check("w64 reg8 rd2",        bus64.rd2_out, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
